tx_data_fifo: RTL and testbench
===============================

Name: tx_data_fifo

Overview:
Byte FIFO that sits directly upstream of the USB transmitter and is the transmit half of the endpoint data buffer. The host-side write path (AHB slave) pushes payload bytes in. The transmitter pops bytes through get_tx_packet_data and reads the head byte on tx_packet_data. The FIFO reports the fill level on buffer_occupancy, which the transmitter uses for packet-length and error decisions.

Parameters:
DEPTH, 64, number of byte entries; must be a power of two.
DATA_W, 8, entry width in bits.
OCC_W, 7, occupancy width; must satisfy 2^OCC_W > DEPTH, i.e. it must be able to represent 0..DEPTH.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
n_rst  input  1  asynchronous active-low reset.
clear  input  1  synchronous flush of all contents and sticky flags.
store_tx_data  input  1  write strobe from the host side.
tx_data  input  DATA_W  write data, sampled when store_tx_data=1.
get_tx_packet_data  input  1  pop strobe from the transmitter.
tx_packet_data  output  DATA_W  head entry (first-word-fall-through).
buffer_occupancy  output  OCC_W  number of valid entries, 0..DEPTH.
fifo_full  output  1  buffer_occupancy == DEPTH.
fifo_empty  output  1  buffer_occupancy == 0.
overflow  output  1  sticky; set on a dropped write.
underflow  output  1  sticky; set on a pop while empty.

Behaviour:
- Reset (n_rst=0, asynchronous):
  - rptr=0, wptr=0.
  - buffer_occupancy=0, fifo_empty=1, fifo_full=0.
  - overflow=0, underflow=0, tx_packet_data=0.
  - Memory contents are don't-care.
- Storage and pointers:
  - Storage is a DEPTH x DATA_W register array.
  - rptr and wptr are log2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0.
  - buffer_occupancy is a registered counter; it is not derived from pointer difference.
- Read data:
  - tx_packet_data = mem[rptr] when fifo_empty=0, else 0. It is combinational from registered state.
  - A newly written byte is visible on tx_packet_data the cycle after the write edge.
- Accepting writes and pops (priority per edge):
  - clear=1 overrides everything: pointers=0, occupancy=0, overflow=0, underflow=0. Any write or pop in that cycle is discarded.
  - Pop accepted = get_tx_packet_data & !fifo_empty.
  - Write accepted = store_tx_data & (!fifo_full | pop accepted).
- Effect on state:
  - Accepted write: mem[wptr]<=tx_data, wptr+1.
  - Accepted pop: rptr+1.
  - Occupancy: +1 on write only, -1 on pop only, unchanged when both or neither occur.
- Flag outputs:
  - fifo_full and fifo_empty are decoded from the registered occupancy.
  - Write while full with no accepted pop: data dropped, state unchanged, overflow<=1.
  - Pop while empty: no state change, underflow<=1. This holds even if a write occurs the same cycle; the write is still accepted and occupancy becomes 1.
  - Full with simultaneous write and pop: both occur, occupancy stays DEPTH, and the new byte lands in the slot just freed by the advancing rptr.
  - overflow and underflow remain set until clear or reset.
- Latency: single-cycle throughput. Write-to-head visibility is 1 cycle; pop-to-next-head is 1 cycle.
- Mid-operation events:
  - Reset mid-operation discards all data immediately.
  - clear asserted while the transmitter is popping yields fifo_empty=1 on the next cycle and tx_packet_data=0.
- There is no state machine beyond the pointer/occupancy datapath. Flag and occupancy updates are fully registered; no combinational path from inputs to buffer_occupancy.

Test Plan:
- Reset then idle -> buffer_occupancy=0, fifo_empty=1, tx_packet_data=8'h00, overflow=0, underflow=0.
- Write 8'hA5, 8'h3C, 8'h81 on consecutive cycles, then pop 3 times -> occupancy goes 1,2,3 then 2,1,0; tx_packet_data shows A5, 3C, 81 in that order; fifo_empty=1 at the end.
- Write 64 bytes 0x00..0x3F, then one more write of 8'hFF -> fifo_full=1, occupancy=64, overflow=1; popping all 64 returns 0x00..0x3F with 8'hFF absent.
- With the FIFO full, assert store_tx_data (8'h77) and get_tx_packet_data together -> occupancy stays 64; head advances from 0x00 to 0x01; after 63 further pops the head is 8'h77.
- Pop on empty with store_tx_data=1 (8'h42) the same cycle -> underflow=1, occupancy=1, tx_packet_data=8'h42 next cycle.
- Wrap and flush:
  - Push/pop 100 bytes with occupancy held near 5, so the pointers wrap past 63 -> data order preserved.
  - Then assert clear with 5 entries present plus a write -> occupancy=0, flags cleared, written byte discarded.

Source files
------------

// File: rtl/tx_data_fifo.sv
// Transmit-side byte FIFO between the AHB write path and the USB transmitter.
// First-word-fall-through head, registered occupancy and sticky error flags.
module tx_data_fifo #(
    parameter int DEPTH  = 64,
    parameter int DATA_W = 8,
    parameter int OCC_W  = 7
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              clear,
    input  logic              store_tx_data,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              get_tx_packet_data,
    output logic [DATA_W-1:0] tx_packet_data,
    output logic [OCC_W-1:0]  buffer_occupancy,
    output logic              fifo_full,
    output logic              fifo_empty,
    output logic              overflow,
    output logic              underflow
);

    localparam int AW = $clog2(DEPTH);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     rptr_q, rptr_d;
    logic [AW-1:0]     wptr_q, wptr_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic              ovf_q, ovf_d;
    logic              unf_q, unf_d;
    logic              pop_ok;
    logic              wr_ok;

    assign fifo_full  = (occ_q == OCC_W'(DEPTH));
    assign fifo_empty = (occ_q == '0);

    assign pop_ok = get_tx_packet_data & ~fifo_empty;
    // A pop on a full FIFO frees the slot the incoming byte lands in.
    assign wr_ok  = store_tx_data & (~fifo_full | pop_ok);

    always_comb begin
        rptr_d = rptr_q;
        wptr_d = wptr_q;
        occ_d  = occ_q;
        ovf_d  = ovf_q;
        unf_d  = unf_q;
        if (clear) begin
            rptr_d = '0;
            wptr_d = '0;
            occ_d  = '0;
            ovf_d  = 1'b0;
            unf_d  = 1'b0;
        end else begin
            if (pop_ok)
                rptr_d = rptr_q + AW'(1);
            if (wr_ok)
                wptr_d = wptr_q + AW'(1);
            if (wr_ok && !pop_ok)
                occ_d = occ_q + OCC_W'(1);
            else if (pop_ok && !wr_ok)
                occ_d = occ_q - OCC_W'(1);
            if (store_tx_data && !wr_ok)
                ovf_d = 1'b1;
            if (get_tx_packet_data && fifo_empty)
                unf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            rptr_q <= '0;
            wptr_q <= '0;
            occ_q  <= '0;
            ovf_q  <= 1'b0;
            unf_q  <= 1'b0;
        end else begin
            rptr_q <= rptr_d;
            wptr_q <= wptr_d;
            occ_q  <= occ_d;
            ovf_q  <= ovf_d;
            unf_q  <= unf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!clear && wr_ok)
            mem_q[wptr_q] <= tx_data;
    end

    assign tx_packet_data   = fifo_empty ? '0 : mem_q[rptr_q];
    assign buffer_occupancy = occ_q;
    assign overflow         = ovf_q;
    assign underflow        = unf_q;

endmodule

// File: tb/tb_tx_data_fifo.sv
// Directed bench for tx_data_fifo: ordering, full/empty edges,
// sticky flags, pointer wrap and synchronous flush.
module tb_tx_data_fifo;

    logic       clk = 1'b0;
    logic       n_rst;
    logic       clear;
    logic       store_tx_data;
    logic [7:0] tx_data;
    logic       get_tx_packet_data;
    logic [7:0] tx_packet_data;
    logic [6:0] buffer_occupancy;
    logic       fifo_full;
    logic       fifo_empty;
    logic       overflow;
    logic       underflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    tx_data_fifo dut (
        .clk                (clk),
        .n_rst              (n_rst),
        .clear              (clear),
        .store_tx_data      (store_tx_data),
        .tx_data            (tx_data),
        .get_tx_packet_data (get_tx_packet_data),
        .tx_packet_data     (tx_packet_data),
        .buffer_occupancy   (buffer_occupancy),
        .fifo_full          (fifo_full),
        .fifo_empty         (fifo_empty),
        .overflow           (overflow),
        .underflow          (underflow)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with the given strobes; returns 1ns after the edge.
    task automatic cyc(input logic st, input logic [7:0] d,
                       input logic pop, input logic clr);
        store_tx_data      = st;
        tx_data            = d;
        get_tx_packet_data = pop;
        clear              = clr;
        @(posedge clk);
        #1;
        store_tx_data      = 1'b0;
        get_tx_packet_data = 1'b0;
        clear              = 1'b0;
        tx_data            = 8'h00;
    endtask

    function automatic logic [7:0] wbyte(input int k);
        return 8'((k * 7 + 3) % 256);
    endfunction

    initial begin
        logic [7:0] sent [3];
        sent[0] = 8'hA5;
        sent[1] = 8'h3C;
        sent[2] = 8'h81;
        n_rst = 1'b0;
        clear = 1'b0;
        store_tx_data = 1'b0;
        get_tx_packet_data = 1'b0;
        tx_data = 8'h00;
        #22;
        n_rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_occ", buffer_occupancy, 0);
        chk("rst_empty", fifo_empty, 1);
        chk("rst_full", fifo_full, 0);
        chk("rst_head", tx_packet_data, 8'h00);
        chk("rst_ovf", overflow, 0);
        chk("rst_unf", underflow, 0);

        // three writes then three pops
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, sent[i], 1'b0, 1'b0);
            chk("w3_occ", buffer_occupancy, 32'(i + 1));
            chk("w3_head", tx_packet_data, 8'hA5);
        end
        for (int i = 0; i < 3; i++) begin
            chk("p3_head", tx_packet_data, sent[i]);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            chk("p3_occ", buffer_occupancy, 32'(2 - i));
        end
        chk("p3_empty", fifo_empty, 1);
        chk("p3_head0", tx_packet_data, 8'h00);

        // fill, overflow, drain
        for (int i = 0; i < 64; i++)
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fill_full", fifo_full, 1);
        chk("fill_occ", buffer_occupancy, 64);
        chk("fill_ovf0", overflow, 0);
        cyc(1'b1, 8'hFF, 1'b0, 1'b0);
        chk("ovf_set", overflow, 1);
        chk("ovf_occ", buffer_occupancy, 64);
        chk("ovf_head", tx_packet_data, 8'h00);
        for (int i = 0; i < 64; i++) begin
            chk("drain_head", tx_packet_data, 32'(i));
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("drain_empty", fifo_empty, 1);
        chk("drain_ovf", overflow, 1);
        chk("drain_unf", underflow, 0);

        // simultaneous push and pop while full
        for (int i = 0; i < 64; i++)
            cyc(1'b1, 8'(i), 1'b0, 1'b0);
        chk("fp_head0", tx_packet_data, 8'h00);
        cyc(1'b1, 8'h77, 1'b1, 1'b0);
        chk("fp_occ", buffer_occupancy, 64);
        chk("fp_full", fifo_full, 1);
        chk("fp_head1", tx_packet_data, 8'h01);
        for (int i = 0; i < 63; i++)
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fp_head77", tx_packet_data, 8'h77);
        chk("fp_occ1", buffer_occupancy, 1);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("fp_empty", fifo_empty, 1);

        // pop on empty with a write in the same cycle
        cyc(1'b1, 8'h42, 1'b1, 1'b0);
        chk("unf_set", underflow, 1);
        chk("unf_occ", buffer_occupancy, 1);
        chk("unf_head", tx_packet_data, 8'h42);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        chk("unf_empty", fifo_empty, 1);

        // wrap with occupancy held at 5
        for (int k = 0; k < 5; k++)
            cyc(1'b1, wbyte(k), 1'b0, 1'b0);
        for (int k = 5; k < 100; k++) begin
            chk("wrap_head", tx_packet_data, wbyte(k - 5));
            cyc(1'b1, wbyte(k), 1'b1, 1'b0);
            chk("wrap_occ", buffer_occupancy, 5);
        end
        chk("wrap_last", tx_packet_data, wbyte(95));

        // flush with 5 entries present plus a write
        cyc(1'b1, 8'h99, 1'b1, 1'b1);
        chk("clr_occ", buffer_occupancy, 0);
        chk("clr_empty", fifo_empty, 1);
        chk("clr_full", fifo_full, 0);
        chk("clr_ovf", overflow, 0);
        chk("clr_unf", underflow, 0);
        chk("clr_head", tx_packet_data, 8'h00);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        chk("clr_hold", buffer_occupancy, 0);

        // asynchronous reset mid-operation
        cyc(1'b1, 8'h5A, 1'b0, 1'b0);
        cyc(1'b1, 8'h6B, 1'b0, 1'b0);
        chk("ar_occ2", buffer_occupancy, 2);
        #2;
        n_rst = 1'b0;
        #1;
        chk("ar_occ", buffer_occupancy, 0);
        chk("ar_empty", fifo_empty, 1);
        chk("ar_head", tx_packet_data, 8'h00);
        n_rst = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
